// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 32-bit adder among NUM_REQ requesters, with locked multi-beat carry chaining.
// Result registered one cycle after accept; while a result awaits rsp_ready every req_ready stays low.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, carry_in};
endmodule

module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_carry,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_last
);
    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        rr_ptr, lk_id, grant_id;
    logic                   lock, chain_c, grant_vld, accept, grant_last;
    logic [NUM_REQ-1:0]     grant_oh, rot_valid;
    logic [2*NUM_REQ-1:0]   dbl_valid;
    logic [ID_W:0]          wrap_sum;
    logic [31:0]            add_a, add_b, add_sum;
    logic                   add_cin, add_cout;

    // Rotating the valid vector by rr_ptr turns the wrapped search into a plain lowest-bit search.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        wrap_sum  = '0;
        dbl_valid = {req_valid, req_valid} >> rr_ptr;
        rot_valid = dbl_valid[NUM_REQ-1:0];
        if (lock) begin
            grant_vld = |(req_valid & (ONE_HOT0 << lk_id));
            grant_id  = lk_id;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (|(rot_valid & (ONE_HOT0 << k))) begin
                    grant_vld = 1'b1;
                    wrap_sum  = {1'b0, rr_ptr} + k[ID_W:0];
                end
            end
            if (wrap_sum >= (ID_W+1)'(NUM_REQ))
                grant_id = ID_W'(wrap_sum - (ID_W+1)'(NUM_REQ));
            else
                grant_id = wrap_sum[ID_W-1:0];
        end
        grant_oh   = ONE_HOT0 << grant_id;
        grant_last = |(req_last & grant_oh);
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready = grant_oh & {NUM_REQ{!rst}};
                    accept    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign add_a   = 32'(req_a >> (32 * grant_id));
    assign add_b   = 32'(req_b >> (32 * grant_id));
    assign add_cin = lock & chain_c;

    adder_32 u_adder (
        .a         (add_a),
        .b         (add_b),
        .carry_in  (add_cin),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // The pointer only advances on a final beat, so a locked chain never loses its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lk_id     <= '0;
            chain_c   <= 1'b0;
        end else if (accept) begin
            rsp_sum   <= add_sum;
            rsp_carry <= add_cout;
            rsp_id    <= grant_id;
            rsp_last  <= grant_last;
            if (grant_last) begin
                lock    <= 1'b0;
                chain_c <= 1'b0;
                rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end else begin
                lock    <= 1'b1;
                lk_id   <= grant_id;
                chain_c <= add_cout;
            end
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed vector table, corner sequences, then random traffic vs a wide-arithmetic model.
module tb_adder_share_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_last = '0;
    logic [N-1:0]        req_ready;
    logic [32*N-1:0]     req_a = '0;
    logic [32*N-1:0]     req_b = '0;
    logic                rsp_valid, rsp_carry, rsp_last;
    logic                rsp_ready = 1'b1;
    logic [31:0]         rsp_sum;
    logic [IW-1:0]       rsp_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
        logic [31:0] sum;
        logic        carry;
    } vec_t;
    vec_t vt[9];

    logic [95:0] op_a[N], op_b[N];
    int          nb[N], bi[N];
    bit          active[N], vb[N];
    int          m_ptr, m_lock, m_id, acc_prev, g, bits, hs;
    bit          m_busy;
    logic [31:0] m_sum;
    logic        m_carry, m_last;
    logic [96:0] mask, s;

    adder_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packed as {valid, last, carry, id, sum}.
    task automatic rsp_chk(input string nm, input logic v, input logic [31:0] es, input logic c,
                           input int id, input logic l);
        check(nm, {27'b0, rsp_valid, rsp_last, rsp_carry, rsp_id, rsp_sum},
                  {27'b0, v, l, c, IW'(id), es});
    endtask

    task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic l);
        logic [32*N-1:0] m;
        logic [N-1:0]    bm;
        m  = {{(32*N-32){1'b0}}, 32'hFFFF_FFFF} << (32 * id);
        bm = {{(N-1){1'b0}}, 1'b1} << id;
        req_a     = (req_a & ~m) | ((32*N)'(a) << (32 * id));
        req_b     = (req_b & ~m) | ((32*N)'(b) << (32 * id));
        req_last  = l ? (req_last | bm) : (req_last & ~bm);
        req_valid = v ? (req_valid | bm) : (req_valid & ~bm);
    endtask

    task automatic set_valid(input int id, input logic v);
        logic [N-1:0] bm;
        bm = {{(N-1){1'b0}}, 1'b1} << id;
        req_valid = v ? (req_valid | bm) : (req_valid & ~bm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // One isolated beat: grant, response exactly one cycle later, then return to IDLE.
    task automatic run_beat(input int id, input logic [31:0] a, input logic [31:0] b, input logic l,
                            input logic [31:0] es, input logic ec);
        logic [N-1:0] bm;
        int           cnt;
        bm  = {{(N-1){1'b0}}, 1'b1} << id;
        cnt = 0;
        drive(id, 1'b1, a, b, l);
        @(negedge clk);
        while ((req_ready & bm) == '0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("beat_grant", req_ready, bm);
        check("beat_early_valid", rsp_valid, 1'b0);
        step();
        set_valid(id, 1'b0);
        @(negedge clk);
        rsp_chk("beat_rsp", 1'b1, es, ec, id, l);
        check("beat_ready_low", req_ready, '0);
        step();
    endtask

    initial begin
        vt[0] = '{0, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0008, 1'b0};
        vt[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1};
        vt[2] = '{2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3568, 1'b0};
        vt[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vt[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 1'b1};
        vt[5] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vt[6] = '{3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0};
        vt[7] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vt[8] = '{2, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

        // Reset state, with every requester valid during reset.
        repeat (2) @(posedge clk);
        #1;
        req_valid = '1;
        @(negedge clk);
        check("reset_ready", req_ready, '0);
        rsp_chk("reset_rsp", 1'b0, 32'h0, 1'b0, 0, 1'b0);
        step();
        rst = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 9; i++)
            run_beat(vt[i].id, vt[i].a, vt[i].b, vt[i].last, vt[i].sum, vt[i].carry);

        // Round-robin fairness from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            drive(i, 1'b1, 32'(i), 32'd100, 1'b1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                check("rr_grant", req_ready, 64'd1 << ((c / 2) % N));
                check("rr_idle_valid", rsp_valid, 1'b0);
            end else begin
                check("rr_ready_low", req_ready, '0);
                rsp_chk("rr_rsp", 1'b1, 32'd100 + 32'((c / 2) % N), 1'b0, (c / 2) % N, 1'b1);
            end
            step();
        end
        req_valid = '0;

        // 64-bit chain on req2 while req1 waits; req2 briefly withdraws mid-lock.
        run_beat(1, 32'h1, 32'h1, 1'b1, 32'h2, 1'b0);
        drive(1, 1'b1, 32'd7, 32'd8, 1'b1);
        drive(2, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        @(negedge clk);
        check("chain_g1", req_ready, 4'b0100);
        step();
        @(negedge clk);
        rsp_chk("chain_beat1", 1'b1, 32'h0, 1'b1, 2, 1'b0);
        step();
        set_valid(2, 1'b0);
        @(negedge clk);
        check("chain_stall", req_ready, '0);
        step();
        drive(2, 1'b1, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("chain_g2", req_ready, 4'b0100);
        step();
        set_valid(2, 1'b0);
        @(negedge clk);
        rsp_chk("chain_beat2", 1'b1, 32'h1, 1'b0, 2, 1'b1);
        step();
        @(negedge clk);
        check("chain_req1", req_ready, 4'b0010);
        step();
        set_valid(1, 1'b0);
        @(negedge clk);
        rsp_chk("chain_req1_rsp", 1'b1, 32'd15, 1'b0, 1, 1'b1);
        step();

        // Backpressure: result held for 5 cycles, exactly one handshake.
        drive(0, 1'b1, 32'hAAAA_0000, 32'h0000_5555, 1'b1);
        @(negedge clk);
        check("bp_grant", req_ready, 4'b0001);
        step();
        set_valid(0, 1'b0);
        drive(3, 1'b1, 32'h1, 32'h2, 1'b1);
        rsp_ready = 1'b0;
        hs = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rsp_chk("bp_hold", 1'b1, 32'hAAAA_5555, 1'b0, 0, 1'b1);
            check("bp_ready_low", req_ready, '0);
            if (rsp_valid && rsp_ready) hs++;
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_chk("bp_release", 1'b1, 32'hAAAA_5555, 1'b0, 0, 1'b1);
        if (rsp_valid && rsp_ready) hs++;
        step();
        @(negedge clk);
        if (rsp_valid && rsp_ready) hs++;
        check("bp_handshakes", 64'(hs), 64'd1);
        check("bp_next_grant", req_ready, 4'b1000);
        step();
        set_valid(3, 1'b0);
        @(negedge clk);
        rsp_chk("bp_next_rsp", 1'b1, 32'h3, 1'b0, 3, 1'b1);
        step();

        // Reset while req3 is locked with a pending response.
        drive(3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        check("rl_grant3", req_ready, 4'b1000);
        step();
        set_valid(3, 1'b0);
        rsp_ready = 1'b0;
        @(negedge clk);
        rsp_chk("rl_pending", 1'b1, 32'hFFFF_FFFE, 1'b1, 3, 1'b0);
        step();
        rst = 1'b1;
        for (int i = 1; i < N; i++)
            drive(i, 1'b1, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        check("rl_ready_in_reset", req_ready, '0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_chk("rl_cleared", 1'b0, 32'h0, 1'b0, 0, 1'b0);
        check("rl_lowest_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        @(negedge clk);
        rsp_chk("rl_no_carry_in", 1'b1, 32'h0, 1'b0, 1, 1'b1);
        step();

        // Random traffic against a model that derives every beat from full-width addition.
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 0; m_lock = -1; m_busy = 1'b0; acc_prev = -1;
        m_sum = '0; m_carry = 1'b0; m_last = 1'b0; m_id = 0;
        for (int i = 0; i < N; i++) begin
            active[i] = 1'b0; vb[i] = 1'b0; nb[i] = 1; bi[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            if (acc_prev >= 0) begin
                bi[acc_prev]++;
                if (bi[acc_prev] == nb[acc_prev]) active[acc_prev] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!active[i] && $urandom_range(3) == 0) begin
                    active[i] = 1'b1;
                    nb[i]     = $urandom_range(3, 1);
                    bi[i]     = 0;
                    op_a[i]   = {rnd32(), rnd32(), rnd32()};
                    op_b[i]   = {rnd32(), rnd32(), rnd32()};
                end
                vb[i] = active[i] && ($urandom_range(7) != 0);
                if (active[i])
                    drive(i, vb[i], 32'(op_a[i] >> (32 * bi[i])), 32'(op_b[i] >> (32 * bi[i])),
                          bi[i] == nb[i] - 1);
                else
                    set_valid(i, 1'b0);
            end
            rsp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            g = -1;
            if (!m_busy) begin
                if (m_lock >= 0) begin
                    if (vb[m_lock]) g = m_lock;
                end else begin
                    for (int k = 0; k < N; k++)
                        if (g < 0 && vb[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            check("rnd_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            if (m_busy)
                rsp_chk("rnd_rsp", 1'b1, m_sum, m_carry, m_id, m_last);
            else
                check("rnd_idle_valid", rsp_valid, 1'b0);
            acc_prev = -1;
            if (m_busy) begin
                if (rsp_ready) m_busy = 1'b0;
            end else if (g >= 0) begin
                bits    = 32 * (bi[g] + 1);
                mask    = (97'd1 << bits) - 97'd1;
                s       = ({1'b0, op_a[g]} & mask) + ({1'b0, op_b[g]} & mask);
                m_sum   = 32'(s >> (32 * bi[g]));
                m_carry = s[bits];
                m_id    = g;
                m_last  = (bi[g] == nb[g] - 1);
                m_busy  = 1'b1;
                acc_prev = g;
                if (m_last) begin
                    m_lock = -1;
                    m_ptr  = (g + 1) % N;
                end else begin
                    m_lock = g;
                end
            end
        end
        step();
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
